// File: rtl/mux_nbit_x4_pkg.sv
// Shared constants for the 4-to-1 valid/ready stream gatherer (mux_nbit_x4_rr).
package mux_nbit_x4_pkg;
  localparam int SEL_W  = 2;
  localparam int NUM_CH = 4;

  localparam logic [SEL_W-1:0] CH_A     = 2'd0;
  localparam logic [SEL_W-1:0] CH_B     = 2'd1;
  localparam logic [SEL_W-1:0] CH_C     = 2'd2;
  localparam logic [SEL_W-1:0] CH_D     = 2'd3;
  localparam logic [SEL_W-1:0] RST_LAST = 2'd3;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [SEL_W-1:0] idx);
    ch_onehot      = '0;
    ch_onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_arbiter_x4.sv
// Four-requester arbiter: round-robin by default, fixed priority a>b>c>d
// when MUX_NBIT_X4_FIXED_PRIO_EN is defined.
module rr_arbiter_x4
  import mux_nbit_x4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any_grant
);

`ifdef MUX_NBIT_X4_FIXED_PRIO_EN
  // No pointer state in this variant; keep the shared port list quiet.
  logic unused_ports;
  assign unused_ports = ^{clk, reset, advance};

  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant_idx = SEL_W'(k);
        any_grant = 1'b1;
      end
    end
  end
`else
  logic [SEL_W-1:0] last_q, last_d;

  // Search last+1 .. last+4; the 2-bit add wraps the index mod 4.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand      = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = last_q + SEL_W'(k);
      if (!any_grant && req[cand]) begin
        grant_idx = cand;
        any_grant = 1'b1;
      end
    end
  end

  assign last_d = (advance && any_grant) ? grant_idx : last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= RST_LAST;
    else       last_q <= last_d;
  end
`endif

  assign grant = any_grant ? ch_onehot(grant_idx) : '0;

endmodule

// File: rtl/mux_nbit_x4_rr.sv
// Gathers four valid/ready streams into one registered output with source tag.
// Arbitration policy selected by MUX_NBIT_X4_FIXED_PRIO_EN (see rr_arbiter_x4).
module mux_nbit_x4_rr
  import mux_nbit_x4_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [BUS_WIDTH-1:0] c,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic [BUS_WIDTH-1:0] d,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic [SEL_W-1:0]     sel,
  output logic                 y_valid,
  input  logic                 y_ready
);

  logic                 load;
  logic [NUM_CH-1:0]    req, grant;
  logic [SEL_W-1:0]     g_idx;
  logic                 any_grant;
  logic [BUS_WIDTH-1:0] mux_data;
  logic [BUS_WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 y_valid_q, y_valid_d;

  // Output slot is free when empty or being drained this cycle.
  assign load = !y_valid_q || y_ready;
  assign req  = {d_valid, c_valid, b_valid, a_valid};

  rr_arbiter_x4 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .advance   (load),
    .grant     (grant),
    .grant_idx (g_idx),
    .any_grant (any_grant)
  );

  assign {d_ready, c_ready, b_ready, a_ready} = (load && !reset) ? grant : '0;

  always_comb begin
    case (g_idx)
      CH_A:    mux_data = a;
      CH_B:    mux_data = b;
      CH_C:    mux_data = c;
      default: mux_data = d;
    endcase
  end

  always_comb begin
    y_d       = y_q;
    sel_d     = sel_q;
    y_valid_d = y_valid_q;
    if (load) begin
      y_valid_d = any_grant;
      if (any_grant) begin
        y_d   = mux_data;
        sel_d = g_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q       <= '0;
      sel_q     <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_q       <= y_d;
      sel_q     <= sel_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign y       = y_q;
  assign sel     = sel_q;
  assign y_valid = y_valid_q;

endmodule

// File: doc/mux_nbit_x4_rr.md
Name: mux_nbit_x4_rr

Overview:
- Merges four BUS_WIDTH-bit valid/ready input streams (a, b, c, d) into one output stream y.
- It is the gathering counterpart to demux_nbit_x4, which steers one bus to four.
- Round-robin arbitration; the output is registered.
- sel reports which channel the current y word came from, so a downstream demux_nbit_x4 can route it back.

Parameters:
- BUS_WIDTH, 8, data width of every channel and of y.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  BUS_WIDTH  channel 0 data.
- a_valid  input  1  channel 0 data valid.
- a_ready  output  1  channel 0 word accepted this cycle.
- b, b_valid, b_ready  same as a, for channel 1.
- c, c_valid, c_ready  same as a, for channel 2.
- d, d_valid, d_ready  same as a, for channel 3.
- y  output  BUS_WIDTH  registered output data.
- sel  output  2  source channel of y (0=a, 1=b, 2=c, 3=d).
- y_valid  output  1  y/sel hold a word.
- y_ready  input  1  downstream accepts y this cycle.

Behaviour:
- Reset (async assert; release is sampled on clk):
  - y=0, sel=0, y_valid=0.
  - Round-robin pointer last=3, so channel a has top priority first.
- load = !y_valid || y_ready. This is combinational: the output register is empty or is being drained.
- Arbitration (combinational):
  - Search the valid inputs in order last+1, last+2, last+3, last (mod 4).
  - The first valid input found is the grant g.
  - If no input is valid, there is no grant.
- Ready outputs: x_ready = load && (grant == x), where x is a, b, c or d.
  - At most one ready is high per cycle.
  - All readies are 0 while in reset.
- On a clk edge with load and a grant:
  - y <= granted data; sel <= g; y_valid <= 1; last <= g.
- On a clk edge with load and no grant:
  - y_valid <= 0.
  - y, sel and last hold their values.
- On a clk edge without load (y_valid=1, y_ready=0):
  - All registers hold.
  - All readies stay 0 (backpressure).
- Latency: 1 cycle from input accept to y_valid.
- Throughput: 1 word/cycle while y_ready=1.
- Fairness: with all four inputs valid continuously and y_ready=1, sel sequence is 0,1,2,3,0,... No channel waits more than 3 grants.
- Producer rule: an input must hold valid and data stable until its ready is seen. The block does not check this.
- Simultaneous drain and refill: y_valid=1, y_ready=1 and an input valid gives a new word the same edge, so y_valid stays 1 with no bubble.
- Reset mid-operation: an in-flight y word is discarded, y_valid drops immediately (async), and the pointer returns to 3.
- sel width is fixed at 2; the channel count is fixed at 4.

Optional Feature:
- Macro: MUX_NBIT_X4_FIXED_PRIO_EN.
- Defined: fixed priority a > b > c > d.
  - The pointer register is removed.
  - Grant is the lowest-indexed valid input.
  - Starvation of lower channels is allowed.
- Undefined (default): round-robin as above.

Decomposition:
- Package mux_nbit_x4_pkg holds:
  - SEL_W=2 and NUM_CH=4.
  - Channel index constants CH_A=0, CH_B=1, CH_C=2, CH_D=3.
  - RST_LAST=3.
- Sub-module rr_arbiter_x4:
  - Inputs: req[3:0], advance, clk, reset.
  - Outputs: one-hot grant[3:0], encoded grant_idx[1:0], any_grant.
  - Owns the last pointer and the FIXED_PRIO_EN variant.
- The top level holds the output register and the data mux.

Test Plan:
- Reset, then idle (all valids 0, y_ready=1) -> y=0, sel=0, y_valid=0, all readies 0 for 5 cycles.
- Only b_valid=1 with b=38, y_ready=1 -> b_ready=1 in that cycle; next cycle y=38, sel=1, y_valid=1.
- All valids held at 1 with a=10, b=20, c=30, d=40, y_ready=1 -> sel 0,1,2,3,0 on successive cycles; y 10,20,30,40,10 (round-robin build).
  - Under MUX_NBIT_X4_FIXED_PRIO_EN the same stimulus gives sel=0, y=10 on every cycle.
- Output held (y=102, sel=1, y_valid=1) with y_ready=0 for 3 cycles while c_valid=1 -> y/sel unchanged and c_ready=0 throughout. Raising y_ready gives c_ready=1 the same cycle and y=c data the next.
- reset asserted mid-stream while y_valid=1 -> y_valid=0, y=0 immediately. After release with all valids at 1, the first grant is sel=0.
- Randomised $urandom data with random valids and y_ready, scoreboard per channel -> every accepted word appears exactly once on y with the correct sel, in per-channel order.
